// File: rtl/serial_operand_tx_if.sv
// Operand-pair handshake plus serial frame bus between a producer and the bit-serial transmitter.
// Latency: none; this is pure wiring.
// Backpressure: in_ready from the transmitter holds the producer; serial side has no backpressure.
interface serial_operand_tx_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             ser_a;
    logic             ser_b;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    // Producer / observer side.
    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, ser_a, ser_b, ser_valid, ser_first, ser_last, busy
    );

    // Transmitter side.
    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, ser_a, ser_b, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/serial_operand_tx.sv
// Shifts a held pair of WIDTH-bit operands out LSB-first on two serial lines with first/last strobes.
// Latency: accept at edge N, load at N+1, bit k on the lines in the cycle after edge N+1+k.
// Backpressure: one-entry holding register; in_ready = !hold_full, registered, so the next pair queues during a frame.
module serial_operand_tx #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    serial_operand_tx_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] hold_a_q, hold_b_q;
    logic             hold_full_q;
    logic             load;
    logic             accept;
    logic             shifting;

    // in_ready is a pure decode of the holding flag, so no path from in_valid exists
    // and an accept can never coincide with the load that empties the register.
    assign accept = bus.in_valid && !hold_full_q;

    // Next-state: frame sequencing and shift-register update.
    always_comb begin
        state_d   = state_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_a_d    = sh_a_q >> 1;
                sh_b_d    = sh_b_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_INIT;
                    end else if (hold_full_q) begin
                        // Back-to-back frame: reload without leaving SHIFT.
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            sh_a_d    = hold_a_q;
            sh_b_d    = hold_b_q;
            bit_cnt_d = '0;
        end
    end

    // State, shift registers and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Holding register: filled on accept, emptied by load (the two never overlap).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_full_q <= 1'b0;
        end else if (load) begin
            hold_full_q <= 1'b0;
        end else if (accept) begin
            hold_a_q    <= bus.in_a;
            hold_b_q    <= bus.in_b;
            hold_full_q <= 1'b1;
        end
    end

    // All outputs decode registered state only, so they are glitch-free and
    // drop to their reset values as soon as reset asserts.
    assign shifting      = (state_q == S_SHIFT);
    assign bus.in_ready  = !hold_full_q;
    assign bus.busy      = (state_q != S_IDLE) || hold_full_q;
    assign bus.ser_valid = shifting;
    assign bus.ser_a     = shifting && sh_a_q[0];
    assign bus.ser_b     = shifting && sh_b_q[0];
    assign bus.ser_first = shifting && (bit_cnt_q == '0);
    assign bus.ser_last  = shifting && (bit_cnt_q == LAST_BIT);
endmodule
